input_sequencer: RTL and testbench

Sample scheduler that feeds the network's input layer during training. It holds a small on-chip buffer of training samples: two inputs plus one target, each DWIDTH-bit signed fixed point. It issues one sample at a time to the forward/backprop datapath over a valid/ready handshake, waits for the datapath to report completion, and repeats for a programmed number of samples and epochs. Its A/B outputs drive the input layer directly. Its target output goes to the output-layer error stage.

---
 rtl/input_sequencer_if.sv | 28 ++
 rtl/input_sequencer.sv | 177 +++++++++++++++++
 tb/tb_input_sequencer.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/input_sequencer_if.sv
// Datapath-facing link of the input sequencer: sample handshake, sample
// payload, position tags and the datapath's completion strobe.
interface input_sequencer_if #(
  parameter int DWIDTH = 32,
  parameter int AW     = 4,
  parameter int EW     = 16
) ();
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DWIDTH-1:0] A;
  logic signed [DWIDTH-1:0] B;
  logic signed [DWIDTH-1:0] target;
  logic        [AW-1:0]     sample_idx;
  logic        [EW-1:0]     epoch_idx;
  logic                     net_done;

  // sequencer side
  modport master (
    output out_valid, A, B, target, sample_idx, epoch_idx,
    input  out_ready, net_done
  );

  // datapath side
  modport slave (
    input  out_valid, A, B, target, sample_idx, epoch_idx,
    output out_ready, net_done
  );
endinterface

// File: rtl/input_sequencer.sv
// input_sequencer: holds a small buffer of training samples (A, B, target)
// and issues them one at a time to the datapath, waiting for net_done
// after each transfer, for a programmed number of samples and epochs.
// Optional feature macro: INPUT_SEQ_PINGPONG_EN -- odd epochs walk the
// buffer from ns-1 down to 0 instead of 0 up to ns-1.
module input_sequencer #(
  parameter int DWIDTH = 32,
  parameter int frac   = 24,
  parameter int NSAMP  = 16,
  parameter int AW     = 4,
  parameter int EW     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic        [AW-1:0]     wr_addr,
  input  logic signed [DWIDTH-1:0] wr_a,
  input  logic signed [DWIDTH-1:0] wr_b,
  input  logic signed [DWIDTH-1:0] wr_t,
  input  logic        [AW:0]       num_samples,
  input  logic        [EW-1:0]     num_epochs,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  input_sequencer_if.master        dp
);

  // frac only describes the fixed-point format downstream; data is passed
  // through untouched, so just reject nonsensical values at elaboration.
  if (frac < 0 || frac >= DWIDTH) begin : g_bad_frac
    $error("input_sequencer: frac must lie in [0, DWIDTH)");
  end

  localparam logic [AW:0] NSAMP_W = (AW+1)'(NSAMP);

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, FINISH} state_t;

  state_t                   state_q, state_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [DWIDTH-1:0] a_q, a_d, b_q, b_d, t_q, t_d;
  logic        [AW-1:0]     sample_idx_q, sample_idx_d;
  logic        [EW-1:0]     epoch_idx_q, epoch_idx_d;
  logic        [AW:0]       ns_q, ns_d;
  logic        [EW-1:0]     ne_q, ne_d;

  logic [3*DWIDTH-1:0] mem [NSAMP];
  logic [3*DWIDTH-1:0] rd_q;

  logic [AW:0] ns_m1;
  logic        rev_cur, rev_nxt, last_s, last_e;

  // traversal direction of the current and of the following epoch
`ifdef INPUT_SEQ_PINGPONG_EN
  assign rev_cur = epoch_idx_q[0];
  assign rev_nxt = ~epoch_idx_q[0];
`else
  assign rev_cur = 1'b0;
  assign rev_nxt = 1'b0;
`endif

  assign ns_m1  = ns_q - (AW+1)'(1);
  assign last_s = rev_cur ? (sample_idx_q == '0) : ({1'b0, sample_idx_q} == ns_m1);
  assign last_e = (epoch_idx_q == ne_q - EW'(1));

  // sample buffer: writes only while idle, synchronous read issued in FETCH;
  // contents survive rst
  always_ff @(posedge clk) begin
    if (wr_en && state_q == IDLE && int'(wr_addr) < NSAMP)
      mem[wr_addr] <= {wr_a, wr_b, wr_t};
    if (state_q == FETCH)
      rd_q <= mem[sample_idx_q];
  end

  // next-state and output logic
  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    out_valid_d  = out_valid_q;
    a_d          = a_q;
    b_d          = b_q;
    t_d          = t_q;
    sample_idx_d = sample_idx_q;
    epoch_idx_d  = epoch_idx_q;
    ns_d         = ns_q;
    ne_d         = ne_q;
    unique case (state_q)
      IDLE: begin
        // busy still set here means this is the done cycle: drop busy first,
        // so a new start is only taken once busy has fallen
        if (busy_q) begin
          busy_d = 1'b0;
        end else if (start && num_samples != '0 && num_epochs != '0) begin
          ns_d         = (num_samples > NSAMP_W) ? NSAMP_W : num_samples;
          ne_d         = num_epochs;
          sample_idx_d = '0;
          epoch_idx_d  = '0;
          busy_d       = 1'b1;
          state_d      = FETCH;
        end
      end
      FETCH: state_d = ISSUE;
      ISSUE: begin
        // first ISSUE cycle latches read data; then hold until accepted
        if (!out_valid_q) begin
          a_d         = rd_q[3*DWIDTH-1 -: DWIDTH];
          b_d         = rd_q[2*DWIDTH-1 -: DWIDTH];
          t_d         = rd_q[DWIDTH-1:0];
          out_valid_d = 1'b1;
        end else if (dp.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (dp.net_done) begin
          if (!last_s) begin
            sample_idx_d = rev_cur ? sample_idx_q - AW'(1) : sample_idx_q + AW'(1);
            state_d      = FETCH;
          end else if (!last_e) begin
            sample_idx_d = rev_nxt ? ns_m1[AW-1:0] : '0;
            epoch_idx_d  = epoch_idx_q + EW'(1);
            state_d      = FETCH;
          end else begin
            state_d = FINISH;
          end
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      t_q          <= '0;
      sample_idx_q <= '0;
      epoch_idx_q  <= '0;
      ns_q         <= '0;
      ne_q         <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      out_valid_q  <= out_valid_d;
      a_q          <= a_d;
      b_q          <= b_d;
      t_q          <= t_d;
      sample_idx_q <= sample_idx_d;
      epoch_idx_q  <= epoch_idx_d;
      ns_q         <= ns_d;
      ne_q         <= ne_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign dp.out_valid  = out_valid_q;
  assign dp.A          = a_q;
  assign dp.B          = b_q;
  assign dp.target     = t_q;
  assign dp.sample_idx = sample_idx_q;
  assign dp.epoch_idx  = epoch_idx_q;

endmodule

// File: tb/tb_input_sequencer.sv
// Bench for input_sequencer: randomized datapath behaviour (ready stalls,
// net_done delays, spurious net_done, writes while busy) against a queue of
// the transfers the run must produce, plus literal timing/order checks.
module tb_input_sequencer;
  localparam int DW = 32;
  localparam int NS = 16;
  localparam int AW = 4;
  localparam int EW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic signed [DW-1:0] wr_a = '0, wr_b = '0, wr_t = '0;
  logic [AW:0] num_samples = '0;
  logic [EW-1:0] num_epochs = '0;
  logic start = 1'b0;
  logic busy, done;

  input_sequencer_if #(.DWIDTH(DW), .AW(AW), .EW(EW)) dpif ();

  input_sequencer #(.DWIDTH(DW), .frac(24), .NSAMP(NS), .AW(AW), .EW(EW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_a(wr_a), .wr_b(wr_b), .wr_t(wr_t),
    .num_samples(num_samples), .num_epochs(num_epochs), .start(start),
    .busy(busy), .done(done), .dp(dpif)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    int          ep;
    logic [31:0] a, b, t;
  } exp_t;

  logic [31:0] ma [NS];
  logic [31:0] mb [NS];
  logic [31:0] mt [NS];
  exp_t exp_q [$];
  int log_idx [$];
  int log_ep [$];
  logic [31:0] log_a [$];
  logic [31:0] log_b [$];
  logic [31:0] log_t [$];

  int checks = 0, errors = 0;
  int cyc = 0, done_cnt = 0, done_cyc = -1, first_valid_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // every cycle with out_valid high the presented sample must be the next
  // expected transfer; a transfer pops it
  always @(negedge clk) begin
    if (!rst) begin
      if (dpif.out_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("valid_unexpected", 64'(dpif.out_valid), 64'd0);
        end else begin
          chk("sample_idx", 64'(dpif.sample_idx), 64'(exp_q[0].idx));
          chk("epoch_idx", 64'(dpif.epoch_idx), 64'(exp_q[0].ep));
          chk("A", 64'($unsigned(dpif.A)), 64'(exp_q[0].a));
          chk("B", 64'($unsigned(dpif.B)), 64'(exp_q[0].b));
          chk("target", 64'($unsigned(dpif.target)), 64'(exp_q[0].t));
          if (dpif.out_ready) begin
            log_idx.push_back(int'(dpif.sample_idx));
            log_ep.push_back(int'(dpif.epoch_idx));
            log_a.push_back($unsigned(dpif.A));
            log_b.push_back($unsigned(dpif.B));
            log_t.push_back($unsigned(dpif.target));
            void'(exp_q.pop_front());
          end
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_with_pending", 64'(exp_q.size()), 64'd0);
      end
    end
  end

  task automatic write_sample(input int addr, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] t);
    wr_en = 1'b1; wr_addr = AW'(addr); wr_a = a; wr_b = b; wr_t = t;
    ma[addr] = a; mb[addr] = b; mt[addr] = t;
    step();
    wr_en = 1'b0;
  endtask

  // transfer order a run must produce, from the counting rules
  task automatic build_exp(input int ns, input int ne);
    int n;
    exp_t e;
    n = (ns > NS) ? NS : ns;
    exp_q.delete();
    for (int ep = 0; ep < ne; ep++) begin
      for (int k = 0; k < n; k++) begin
        e.idx = k;
`ifdef INPUT_SEQ_PINGPONG_EN
        if (ep % 2 == 1) e.idx = n - 1 - k;
`endif
        e.ep = ep;
        e.a = ma[e.idx]; e.b = mb[e.idx]; e.t = mt[e.idx];
        exp_q.push_back(e);
      end
    end
  endtask

  // mode 0: ready high, net_done the cycle after transfer
  // mode 1: random ready, random net_done delay, spurious net_done
  // mode 2: ready held low for 5 valid cycles, then high
  task automatic run_job(input int ns, input int ne, input int mode, input int abort_at);
    int acc, nd_last, last_x, d0, dly, bp;
    bit pend, xfer, real_nd, got_done;
    build_exp(ns, ne);
    log_idx.delete(); log_ep.delete(); log_a.delete(); log_b.delete(); log_t.delete();
    first_valid_cyc = -1; d0 = done_cnt; pend = 0; last_x = -1; nd_last = -1;
    bp = 0; dly = 0; got_done = 0;
    num_samples = (AW+1)'(ns); num_epochs = EW'(ne); start = 1'b1;
    step();
    start = 1'b0;
    acc = cyc;
    for (int c = 0; c < 4000 && !got_done; c++) begin
      net_done_drive: begin
        dpif.net_done = 1'b0; wr_en = 1'b0; real_nd = 0;
        if (pend) begin
          if (dly == 0) begin dpif.net_done = 1'b1; real_nd = 1; pend = 0; end
          else dly--;
        end
      end
      case (mode)
        0: dpif.out_ready = 1'b1;
        1: dpif.out_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (dpif.out_valid && bp < 5) begin dpif.out_ready = 1'b0; bp++; end
          else dpif.out_ready = 1'b1;
        end
      endcase
      if (mode != 0 && !pend && !real_nd && dpif.out_valid && !dpif.out_ready &&
          $urandom_range(0, 1) == 1)
        dpif.net_done = 1'b1;
      if (dpif.out_valid && $urandom_range(0, 1) == 1) begin
        wr_en = 1'b1; wr_addr = AW'($urandom_range(0, NS - 1));
        wr_a = $urandom; wr_b = $urandom; wr_t = $urandom;
      end
      xfer = dpif.out_valid && dpif.out_ready;
      step();
      if (real_nd) nd_last = cyc;
      if (xfer) begin
        if (mode == 0 && last_x >= 0) chk("throughput", 64'(cyc - last_x), 64'd4);
        last_x = cyc; pend = 1;
        dly = (mode == 1) ? $urandom_range(0, 3) : 0;
        if (abort_at > 0 && log_idx.size() == abort_at) begin
          rst = 1'b1; dpif.net_done = 1'b0; wr_en = 1'b0; exp_q.delete();
          step();
          rst = 1'b0;
          @(negedge clk);
          chk("rst_busy", 64'(busy), 64'd0);
          chk("rst_valid", 64'(dpif.out_valid), 64'd0);
          chk("rst_sidx", 64'(dpif.sample_idx), 64'd0);
          chk("rst_eidx", 64'(dpif.epoch_idx), 64'd0);
          chk("rst_A", 64'($unsigned(dpif.A)), 64'd0);
          for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rst_no_done", 64'(done), 64'd0);
          end
          chk("rst_no_pulse", 64'(done_cnt - d0), 64'd0);
          step();
          return;
        end
      end
      if (done_cnt != d0) got_done = 1;
    end
    dpif.net_done = 1'b0; wr_en = 1'b0;
    if (!got_done) begin
      chk("timeout_done", 64'(got_done), 64'd1);
    end else begin
      chk("done_latency", 64'(done_cyc - nd_last), 64'd1);
      chk("busy_drop", 64'(busy), 64'd0);
      chk("done_one_cycle", 64'(done), 64'd0);
      chk("done_pulses", 64'(done_cnt - d0), 64'd1);
      chk("start_latency", 64'(first_valid_cyc - acc), 64'd2);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
    end
  endtask

  initial begin
    int ord [6];
    int d0;
    dpif.out_ready = 1'b0;
    dpif.net_done  = 1'b0;
    for (int i = 0; i < NS; i++) begin ma[i] = '0; mb[i] = '0; mt[i] = '0; end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_valid", 64'(dpif.out_valid), 64'd0);
    chk("reset_A", 64'($unsigned(dpif.A)), 64'd0);
    chk("reset_B", 64'($unsigned(dpif.B)), 64'd0);
    chk("reset_T", 64'($unsigned(dpif.target)), 64'd0);
    chk("reset_sidx", 64'(dpif.sample_idx), 64'd0);
    chk("reset_eidx", 64'(dpif.epoch_idx), 64'd0);
    step();

    // zero-count starts are ignored
    d0 = done_cnt;
    num_samples = '0; num_epochs = EW'(3); start = 1'b1;
    step();
    num_samples = (AW+1)'(2); num_epochs = '0;
    step();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("zero_busy", 64'(busy), 64'd0);
      chk("zero_valid", 64'(dpif.out_valid), 64'd0);
      chk("zero_A", 64'($unsigned(dpif.A)), 64'd0);
    end
    chk("zero_no_done", 64'(done_cnt - d0), 64'd0);
    step();

    // single pass over the pattern samples
    for (int k = 0; k < 4; k++)
      write_sample(k, 32'(k) << 24, -(32'(k) << 24), 32'd0);
    run_job(4, 1, 0, 0);
    chk("sp_count", 64'(log_idx.size()), 64'd4);
    for (int k = 0; k < log_idx.size(); k++)
      chk("sp_order", 64'(log_idx[k]), 64'(k));
    if (log_idx.size() == 4) begin
      chk("sp_A1", 64'(log_a[1]), 64'h0100_0000);
      chk("sp_B1", 64'(log_b[1]), 64'hFF00_0000);
      chk("sp_A3", 64'(log_a[3]), 64'h0300_0000);
      chk("sp_B3", 64'(log_b[3]), 64'hFD00_0000);
      chk("sp_T3", 64'(log_t[3]), 64'd0);
    end

    // backpressure with spurious net_done while stalled in ISSUE
    run_job(4, 1, 2, 0);
    chk("bp_count", 64'(log_idx.size()), 64'd4);

    // two epochs of three samples
    run_job(3, 2, 1, 0);
`ifdef INPUT_SEQ_PINGPONG_EN
    ord = '{0, 1, 2, 2, 1, 0};
`else
    ord = '{0, 1, 2, 0, 1, 2};
`endif
    chk("me_count", 64'(log_idx.size()), 64'd6);
    for (int k = 0; k < 6 && k < log_idx.size(); k++) begin
      chk("me_order", 64'(log_idx[k]), 64'(ord[k]));
      chk("me_epoch", 64'(log_ep[k]), 64'(k / 3));
    end

    // full buffer, count clamp
    for (int k = 0; k < NS; k++) write_sample(k, $urandom, $urandom, $urandom);
    run_job(NS + 1, 1, 1, 0);
    chk("clamp_count", 64'(log_idx.size()), 64'(NS));

    // random runs
    for (int j = 0; j < 4; j++) begin
      write_sample($urandom_range(0, NS - 1), $urandom, $urandom, $urandom);
      run_job($urandom_range(1, NS + 1), $urandom_range(1, 3), 1, 0);
    end

    // reset in WAIT of sample 2, then replay from sample 0
    run_job(4, 1, 0, 3);
    run_job(4, 1, 0, 0);
    chk("replay_first", (log_idx.size() > 0) ? 64'(log_idx[0]) : 64'hDEAD, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
